// File: rtl/serial_deserializer8_if.sv
// rtl/serial_deserializer8_if.sv - serial bit input and parallel word output handshake bundle
interface serial_deserializer8_if #(
  parameter int WIDTH = 8
);
  logic             in_bit;
  logic             in_valid;
  logic             in_start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_bit, in_valid, in_start, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_bit, in_valid, in_start, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/serial_deserializer8.sv
// rtl/serial_deserializer8.sv - collects WIDTH serial bits into a word, presented on valid/ready
module serial_deserializer8 #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IW        = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  serial_deserializer8_if.slave  sif,
  output logic [IW-1:0]          bit_index,
  output logic                   overrun,
  output logic                   sync_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [WIDTH-1:0] word_next;
  logic             new_frame;
  logic             accept;
  logic             complete;
  logic             out_free;
  int               slot;
  int               pos;

  assign sif.out_data  = data_q;
  assign sif.out_valid = valid_q;

  // A start bit (or any accepted bit in IDLE) begins from an empty word at slot 0.
  always_comb begin
    new_frame = sif.in_start || (state == ST_IDLE);
    slot      = new_frame ? 0 : int'(bit_index);
    pos       = MSB_FIRST ? (WIDTH - 1 - slot) : slot;
    word_next = new_frame ? '0 : shift_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == pos) word_next[k] = sif.in_bit;
    end
    accept    = sif.in_valid && ((state == ST_COLLECT) || sif.in_start);
    complete  = sif.in_valid && !sif.in_start && (state == ST_COLLECT) &&
                (bit_index == IW'(WIDTH - 1));
    out_free  = !valid_q || sif.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_index <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      bit_index <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          state     <= ST_IDLE;
          bit_index <= '0;
          shift_q   <= '0;
        end else begin
          state     <= ST_COLLECT;
          shift_q   <= word_next;
          bit_index <= sif.in_start ? IW'(1) : bit_index + IW'(1);
        end
        if (sif.in_start && (state == ST_COLLECT)) sync_err <= 1'b1;
      end
      // Loading wins over draining so a same-cycle drain/load has no bubble.
      if (complete && out_free) begin
        data_q  <= word_next;
        valid_q <= 1'b1;
      end else begin
        if (complete) overrun <= 1'b1;
        if (valid_q && sif.out_ready) valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer8.sv
// tb/tb_serial_deserializer8.sv - LSB-first and MSB-first instances against a queue-based frame model
module tb_serial_deserializer8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  logic [2:0] bi_l, bi_m;
  logic       ov_l, ov_m, se_l, se_m;
  int         compared = 0;
  int         mismatched = 0;

  logic       mq[$];
  logic       mv;
  logic [7:0] md_l, md_m;
  logic       mov, mse;

  always #5 clk = ~clk;

  serial_deserializer8_if #(.WIDTH(8)) ifl ();
  serial_deserializer8_if #(.WIDTH(8)) ifm ();

  serial_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .clear(clr), .sif(ifl.slave),
    .bit_index(bi_l), .overrun(ov_l), .sync_err(se_l)
  );

  serial_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clr), .sif(ifm.slave),
    .bit_index(bi_m), .overrun(ov_m), .sync_err(se_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] assemble(input logic msb);
    logic [7:0] w = 8'h00;
    for (int k = 0; k < 8; k++)
      w = w + (8'(mq[k]) << (msb ? 7 - k : k));
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    mv = 1'b0; md_l = 8'h00; md_m = 8'h00; mov = 1'b0; mse = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic s);
    logic       done = 1'b0;
    logic [7:0] wl = 8'h00, wm = 8'h00;
    if (clr) begin
      model_reset();
      return;
    end
    if (v) begin
      if (s) begin
        if (mq.size() != 0) mse = 1'b1;
        mq.delete();
        mq.push_back(b);
      end else if (mq.size() != 0) begin
        mq.push_back(b);
        if (mq.size() == 8) begin
          wl = assemble(1'b0);
          wm = assemble(1'b1);
          done = 1'b1;
          mq.delete();
        end
      end
    end
    if (done) begin
      if (!mv || rdy) begin
        md_l = wl; md_m = wm; mv = 1'b1;
      end else begin
        mov = 1'b1;
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
  endtask

  task automatic check_all();
    check("valid_l", 32'(ifl.out_valid), 32'(mv));
    check("valid_m", 32'(ifm.out_valid), 32'(mv));
    check("data_l", 32'(ifl.out_data), 32'(md_l));
    check("data_m", 32'(ifm.out_data), 32'(md_m));
    check("bit_index_l", 32'(bi_l), 32'(mq.size()));
    check("bit_index_m", 32'(bi_m), 32'(mq.size()));
    check("overrun_l", 32'(ov_l), 32'(mov));
    check("overrun_m", 32'(ov_m), 32'(mov));
    check("sync_err_l", 32'(se_l), 32'(mse));
    check("sync_err_m", 32'(se_m), 32'(mse));
  endtask

  task automatic step(input logic b, input logic v, input logic s);
    ifl.in_bit = b; ifl.in_valid = v; ifl.in_start = s; ifl.out_ready = rdy;
    ifm.in_bit = b; ifm.in_valid = v; ifm.in_start = s; ifm.out_ready = rdy;
    model_step(b, v, s);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [7:0] w, input logic msb_order, input int gap_max);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, gap_max))
        step(1'($urandom), 1'b0, 1'($urandom));
      step(msb_order ? w[7-k] : w[k], 1'b1, k == 0);
    end
  endtask

  initial begin
    ifl.in_bit = 1'b0; ifl.in_valid = 1'b0; ifl.in_start = 1'b0; ifl.out_ready = 1'b0;
    ifm.in_bit = 1'b0; ifm.in_valid = 1'b0; ifm.in_start = 1'b0; ifm.out_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    rdy = 1'b1;
    send_frame(8'hA5, 1'b0, 0);
    check("a5_lsb", 32'(ifl.out_data), 32'h A5);
    check("a5_msb", 32'(ifm.out_data), 32'h A5);
    step(1'b0, 1'b0, 1'b0);
    check("a5_one_cycle", 32'(ifl.out_valid), 32'h0);

    send_frame(8'h3C, 1'b1, 0);
    check("3c_msb", 32'(ifm.out_data), 32'h3C);
    step(1'b0, 1'b0, 1'b0);

    send_frame(8'h81, 1'b0, 5);
    check("81_gapped", 32'(ifl.out_data), 32'h81);
    step(1'b0, 1'b0, 1'b0);

    rdy = 1'b0;
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    check("overrun_hold", 32'(ifl.out_data), 32'h11);
    check("overrun_flag", 32'(ov_l), 32'h1);
    rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("overrun_drain", 32'(ifl.out_valid), 32'h0);
    send_frame(8'h33, 1'b0, 0);
    check("after_overrun", 32'(ifl.out_data), 32'h33);
    check("overrun_sticky", 32'(ov_l), 32'h1);
    step(1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 0);
    check("resync_flag", 32'(se_l), 32'h1);
    check("resync_data", 32'(ifl.out_data), 32'hF0);
    step(1'b0, 1'b0, 1'b0);

    rdy = 1'b0;
    send_frame(8'h55, 1'b0, 0);
    begin
      logic [7:0] aa = 8'hAA;
      for (int k = 0; k < 8; k++) begin
        rdy = (k == 7);
        step(aa[k], 1'b1, k == 0);
      end
    end
    check("overlap_valid", 32'(ifl.out_valid), 32'h1);
    check("overlap_data", 32'(ifl.out_data), 32'hAA);

    for (int i = 0; i < 400; i++) begin
      rdy = 1'($urandom);
      clr = ($urandom_range(0, 149) == 0);
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0);
    end
    clr = 1'b0;

    rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
